multiplier_booth: RTL and testbench

Sequential 16-bit signed fixed-point multiplier that uses radix-2 Booth recoding and processes one multiplier bit per clock. It is the multiply primitive of the fixed-point arithmetic library that feeds the ODE accelerator datapath. There is no start strobe: the block restarts by itself whenever its operands change. It then reports a saturated Q6.10 product, an overflow flag and a `finish` level.

---
 rtl/multiplier_booth.sv | 85 ++++++++
 tb/tb_multiplier_booth.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multiplier_booth.sv
// Signed Q6.10 multiplier, radix-2 Booth, one multiplier bit per clock, saturating output.
// Latency: 17 edges from the first edge that samples new operands (load + 16 steps).
// Backpressure: none; any operand change aborts the current product and restarts.
module multiplier_booth (
  input  logic        clk,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] result,
  output logic        overflow_flag,
  output logic        finish,
  input  logic        rst_n
);

  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [16:0] acc;
  logic [15:0] q;
  logic        q_1;
  logic [4:0]  step_cnt;
  logic        busy;
  logic        loaded;

  logic        load;
  logic [16:0] a_ext;
  logic [16:0] sum;
  logic [16:0] acc_nxt;
  logic [15:0] q_nxt;
  logic [31:0] prod;
  logic        ovf;
  logic [15:0] sat_val;

  always_comb begin
    load  = !loaded || ({A, B} != {a_q, b_q});
    a_ext = {a_q[15], a_q};
    case ({q[0], q_1})
      2'b01:   sum = acc + a_ext;
      2'b10:   sum = acc - a_ext;
      default: sum = acc;
    endcase
    acc_nxt = {sum[16], sum[16:1]};
    q_nxt   = {sum[0], q[15:1]};
    // Product as it stands after this step; only meaningful on the 16th step.
    prod    = {acc_nxt[15:0], q_nxt};
    ovf     = !((&prod[31:25]) || !(|prod[31:25]));
    sat_val = prod[31] ? 16'h8000 : 16'h7FFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q           <= '0;
      b_q           <= '0;
      acc           <= '0;
      q             <= '0;
      q_1           <= 1'b0;
      step_cnt      <= '0;
      busy          <= 1'b0;
      loaded        <= 1'b0;
      result        <= '0;
      overflow_flag <= 1'b0;
      finish        <= 1'b0;
    end else if (load) begin
      a_q      <= A;
      b_q      <= B;
      acc      <= '0;
      q        <= B;
      q_1      <= 1'b0;
      step_cnt <= '0;
      busy     <= 1'b1;
      loaded   <= 1'b1;
      finish   <= 1'b0;
    end else if (busy) begin
      acc      <= acc_nxt;
      q        <= q_nxt;
      q_1      <= q[0];
      step_cnt <= step_cnt + 5'd1;
      if (step_cnt == 5'd15) begin
        busy          <= 1'b0;
        finish        <= 1'b1;
        result        <= ovf ? sat_val : prod[25:10];
        overflow_flag <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_multiplier_booth.sv
// Self-checking bench for multiplier_booth: directed Q6.10 cases, abort/reset behaviour, random back-to-back.
module tb_multiplier_booth;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] result;
  logic        overflow_flag;
  logic        finish;

  int checks   = 0;
  int failures = 0;

  logic [16:0] exp_q[$];
  logic [16:0] last_exp;

  always #5 clk = ~clk;

  multiplier_booth dut (
    .clk           (clk),
    .A             (A),
    .B             (B),
    .result        (result),
    .overflow_flag (overflow_flag),
    .finish        (finish),
    .rst_n         (rst_n)
  );

  // Reference: full-precision signed product, floor to Q6.10, saturate.
  function automatic logic [16:0] golden(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    if (p[31:25] == 7'h7F || p[31:25] == 7'h00)
      return {1'b0, p[25:10]};
    else
      return {1'b1, (p[31] ? 16'h8000 : 16'h7FFF)};
  endfunction

  // Apply operands at a falling edge, then check latency, hold behaviour and the product.
  task automatic run_vec(input logic [15:0] a, input logic [15:0] b,
                         input logic [16:0] exp, input string name, input bit release_rst);
    logic [16:0] e;
    @(negedge clk);
    A = a;
    B = b;
    if (release_rst) rst_n = 1'b1;
    exp_q.push_back(exp);
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        checks++;
        if (finish !== 1'b0) begin
          failures++;
          $display("FAIL %s finish_after_load got=%b want=0", name, finish);
        end
      end
      if (i == 16) begin
        checks++;
        if (finish !== 1'b0) begin
          failures++;
          $display("FAIL %s finish_early got=%b want=0", name, finish);
        end
        checks++;
        if ({overflow_flag, result} !== last_exp) begin
          failures++;
          $display("FAIL %s output_held got=%h want=%h", name, {overflow_flag, result}, last_exp);
        end
      end
    end
    checks++;
    if (finish !== 1'b1) begin
      failures++;
      $display("FAIL %s finish_at_17 got=%b want=1", name, finish);
    end
    e = exp_q.pop_front();
    checks++;
    if ({overflow_flag, result} !== e) begin
      failures++;
      $display("FAIL %s product a=%h b=%h got ovf=%b res=%h want ovf=%b res=%h",
               name, a, b, overflow_flag, result, e[16], e[15:0]);
    end
    last_exp = e;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    A = 16'h0400;
    B = 16'h0400;
    last_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({finish, overflow_flag, result} !== 18'h0) begin
      failures++;
      $display("FAIL reset_state got fin=%b ovf=%b res=%h want 0/0/0000", finish, overflow_flag, result);
    end
    run_vec(16'h0400, 16'h0400, {1'b0, 16'h0400}, "reset_release", 1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    A = 16'h0A00;
    B = 16'hFA00;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({finish, overflow_flag, result} !== 18'h0) begin
      failures++;
      $display("FAIL reset_mid got fin=%b ovf=%b res=%h want 0/0/0000", finish, overflow_flag, result);
    end
    last_exp = '0;
    run_vec(16'h0A00, 16'hFA00, {1'b0, 16'hF100}, "reset_mid_release", 1'b1);
  endtask

  task automatic test_signed_mix();
    run_vec(16'h0000, 16'h7FFF, {1'b0, 16'h0000}, "zero_mul", 1'b0);
    run_vec(16'h0A00, 16'hFA00, {1'b0, 16'hF100}, "signed_mix", 1'b0);
  endtask

  task automatic test_overflow();
    run_vec(16'h4000, 16'h1000, {1'b1, 16'h7FFF}, "ovf_pos", 1'b0);
    run_vec(16'h8000, 16'h8000, {1'b1, 16'h7FFF}, "ovf_minmin", 1'b0);
    run_vec(16'h8000, 16'h0800, {1'b1, 16'h8000}, "ovf_neg", 1'b0);
  endtask

  task automatic test_truncation();
    run_vec(16'h0001, 16'h0001, {1'b0, 16'h0000}, "trunc_pos", 1'b0);
    run_vec(16'hFFFF, 16'h0001, {1'b0, 16'hFFFF}, "trunc_floor", 1'b0);
  endtask

  task automatic test_mid_change();
    @(negedge clk);
    A = 16'h0A00;
    B = 16'h0400;
    // load edge plus five step edges, then the operands change
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (finish !== 1'b0) begin
      failures++;
      $display("FAIL mid_change_busy finish got=%b want=0", finish);
    end
    run_vec(16'h0300, 16'h0800, {1'b0, 16'h0600}, "mid_change", 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [15:0] b;
    for (int n = 0; n < 100; n++) begin
      do begin
        a = 16'($urandom);
        b = 16'($urandom);
        if (n % 4 == 1) a = {a[15], 5'h00, a[9:0]};
      end while ({a, b} == {A, B});
      run_vec(a, b, golden(a, b), "random", 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    A = '0;
    B = '0;
    last_exp = '0;
    test_reset();
    test_reset_mid();
    test_signed_mix();
    test_overflow();
    test_truncation();
    test_mid_change();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
